// File: rtl/rsign_unit.sv
// rsign_unit: ReActNet RSign stage. Every activation is compared against its channel threshold in parallel, with a registered 1-bit result.
// Optional macro RSIGN_OUT_VALID_EN adds a registered data_out_valid port that marks each new result.
module rsign_unit #(
    parameter int unsigned FM_DEPTH  = 64,
    parameter int unsigned CORE_SIZE = 9
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_in_valid,
    input  logic [15:0] para_in  [FM_DEPTH],
    input  logic [15:0] data_in  [FM_DEPTH][CORE_SIZE],
    output logic        data_out [FM_DEPTH][CORE_SIZE]
`ifdef RSIGN_OUT_VALID_EN
    ,
    output logic        data_out_valid
`endif
);

    logic ge [FM_DEPTH][CORE_SIZE];

    // A direct signed compare cannot overflow, unlike a 16-bit difference.
    for (genvar gi = 0; gi < FM_DEPTH; gi++) begin : g_ch
        for (genvar gj = 0; gj < CORE_SIZE; gj++) begin : g_pos
            assign ge[gi][gj] = $signed(data_in[gi][gj]) >= $signed(para_in[gi]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FM_DEPTH; i++) begin
                for (int unsigned j = 0; j < CORE_SIZE; j++) begin
                    data_out[i][j] <= 1'b0;
                end
            end
        end else if (data_in_valid) begin
            for (int unsigned i = 0; i < FM_DEPTH; i++) begin
                for (int unsigned j = 0; j < CORE_SIZE; j++) begin
                    data_out[i][j] <= ge[i][j];
                end
            end
        end
    end

`ifdef RSIGN_OUT_VALID_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= data_in_valid;
        end
    end
`endif

endmodule

// File: tb/tb_rsign_unit.sv
// Scoreboard bench for rsign_unit: stimulus pushes the expected sign map per edge, a monitor pops and compares after the edge.
module tb_rsign_unit;

    localparam int FD = 64;
    localparam int CS = 9;
    localparam int NB = FD * CS;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic [15:0] p [FD];
    logic [15:0] d [FD][CS];
    logic        q [FD][CS];
`ifdef RSIGN_OUT_VALID_EN
    logic        q_valid;
`endif

    rsign_unit #(.FM_DEPTH(FD), .CORE_SIZE(CS)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .data_in_valid (valid),
        .para_in       (p),
        .data_in       (d),
        .data_out      (q)
`ifdef RSIGN_OUT_VALID_EN
        ,
        .data_out_valid(q_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NB-1:0] exp_q  [$];
    logic          vld_q  [$];
    string         name_q [$];

    int tests = 0;
    int fails = 0;
    logic [NB-1:0] held;

    // Reference compare done as a wide integer difference.
    function automatic logic [NB-1:0] model();
        logic [NB-1:0] m;
        int diff;
        m = '0;
        for (int i = 0; i < FD; i++) begin
            for (int j = 0; j < CS; j++) begin
                diff = int'($signed(d[i][j])) - int'($signed(p[i]));
                m[i*CS+j] = (diff >= 0);
            end
        end
        return m;
    endfunction

    task automatic set_bg();
        for (int i = 0; i < FD; i++) begin
            p[i] = 16'h0000;
            for (int j = 0; j < CS; j++) d[i][j] = 16'h0000;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < FD; i++) begin
            p[i] = 16'($urandom());
            for (int j = 0; j < CS; j++) begin
                d[i][j] = 16'($urandom());
                if ($urandom_range(0, 7) == 0) d[i][j] = p[i];
            end
        end
    endtask

    // Drive one edge and queue what data_out must show after it.
    task automatic step(input logic r, input logic v, input logic [NB-1:0] e, input string nm);
        rstn  = r;
        valid = v;
        exp_q.push_back(e);
        vld_q.push_back(r & v);
        name_q.push_back(nm);
        held = e;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [NB-1:0] act, e;
        logic ev;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ev = vld_q.pop_front();
                nm = name_q.pop_front();
                for (int i = 0; i < FD; i++)
                    for (int j = 0; j < CS; j++)
                        act[i*CS+j] = q[i][j];
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL %s: data_out got %h expected %h", nm, act, e);
                end
`ifdef RSIGN_OUT_VALID_EN
                tests++;
                if (q_valid !== ev) begin
                    fails++;
                    $display("FAIL %s_valid: data_out_valid got %b expected %b", nm, q_valid, ev);
                end
`else
                if (ev === 1'bx) $display("unreachable");
`endif
            end
        end
    end

    initial begin : stim
        logic [NB-1:0] e;
        rstn  = 1'b0;
        valid = 1'b0;
        set_bg();

        for (int k = 0; k < 4; k++) begin
            set_rand();
            step(1'b0, 1'b1, '0, "reset");
        end

        // Basic compare: ch0 threshold 100; other channels 0 vs 0 give 1.
        set_bg();
        p[0] = 16'sd100;
        d[0][0] = 16'sd99; d[0][1] = 16'sd100; d[0][2] = 16'sd101;
        e = '1;
        e[0] = 1'b0;
        for (int j = 3; j < CS; j++) e[j] = 1'b0;
        step(1'b1, 1'b1, e, "basic");

        // Signed extremes: ch1 at most-negative threshold, ch2 at most-positive.
        set_bg();
        p[1] = 16'h8000; d[1][0] = 16'h8000; d[1][1] = 16'h7FFF;
        p[2] = 16'h7FFF; d[2][0] = 16'h8000;
        e = '1;
        for (int j = 0; j < CS; j++) e[2*CS+j] = 1'b0;
        step(1'b1, 1'b1, e, "extremes");

        // Negative threshold on ch3.
        set_bg();
        p[3] = -16'sd5;
        d[3][0] = -16'sd6; d[3][1] = -16'sd5; d[3][2] = 16'sd0;
        e = '1;
        e[3*CS+0] = 1'b0;
        step(1'b1, 1'b1, e, "negthr");

        // Hold: one valid pulse per 16 cycles, inputs churn in between.
        for (int h = 0; h < 3; h++) begin
            set_rand();
            step(1'b1, 1'b1, model(), "hold_load");
            for (int k = 0; k < 15; k++) begin
                set_rand();
                step(1'b1, 1'b0, held, "hold");
            end
        end

        // Mid-operation reset, then a normal result right after.
        set_rand();
        step(1'b0, 1'b1, '0, "mid_reset");
        set_rand();
        step(1'b1, 1'b1, model(), "post_reset");

        // Random: 100 valid pulses with occasional idle gaps.
        for (int k = 0; k < 100; k++) begin
            set_rand();
            step(1'b1, 1'b1, model(), "random");
            if ($urandom_range(0, 3) == 0) begin
                set_rand();
                step(1'b1, 1'b0, held, "random_idle");
            end
        end

        valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: queue depth got %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
